// File: rtl/rf_rename_ckpt.sv
// Architectural register file with rename tags, same-cycle read bypass and a
// circular set of tag/busy checkpoints for single-cycle mispredict recovery.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module rf_rename_ckpt #(
  parameter int NUM_REGS   = 32,
  parameter int XLEN       = 32,
  parameter int TAG_W      = `ROB_SIZE_BIT,
  parameter int NUM_RD     = 2,
  parameter int CKPT_DEPTH = 4,
  parameter int CKPT_W     = $clog2(CKPT_DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    cmt_en_in,
  input  logic [4:0]              cmt_id_in,
  input  logic [TAG_W-1:0]        cmt_tag_in,
  input  logic [XLEN-1:0]         cmt_val_in,
  input  logic                    ren_en_in,
  input  logic [4:0]              ren_id_in,
  input  logic [TAG_W-1:0]        ren_tag_in,
  input  logic [NUM_RD*5-1:0]     rd_id_in,
  output logic [NUM_RD*XLEN-1:0]  rd_val_out,
  output logic [NUM_RD*TAG_W-1:0] rd_tag_out,
  output logic [NUM_RD-1:0]       rd_busy_out,
  input  logic                    ckpt_save_in,
  output logic [CKPT_W-1:0]       ckpt_id_out,
  input  logic                    ckpt_release_in,
  input  logic                    ckpt_restore_in,
  input  logic [CKPT_W-1:0]       ckpt_restore_id_in,
  output logic                    ckpt_full_out,
  output logic                    ckpt_empty_out
);

  typedef logic [NUM_REGS-1:0][TAG_W-1:0] tag_tbl_t;

  logic [XLEN-1:0]     val [NUM_REGS];
  tag_tbl_t            tag, tag_nx;
  logic [NUM_REGS-1:0] busy, busy_nx, rst_busy;
  tag_tbl_t            s_tag [CKPT_DEPTH];
  logic [NUM_REGS-1:0] s_busy [CKPT_DEPTH];
  logic [CKPT_W-1:0]   head, tail, head_rel, rst_off;
  logic [CKPT_W:0]     count, count_rel;
  logic                cmt_ok, ren_ok, rel_ok, rst_ok, sav_ok, full, byp;

  assign cmt_ok    = rdy_in & cmt_en_in & (cmt_id_in != 5'd0);
  assign ren_ok    = rdy_in & ren_en_in & (ren_id_in != 5'd0);
  assign full      = (count == (CKPT_W+1)'(CKPT_DEPTH));
  assign rel_ok    = rdy_in & ckpt_release_in & (count != '0);
  assign head_rel  = head + CKPT_W'(rel_ok);
  assign count_rel = count - (CKPT_W+1)'(rel_ok);
  // Restore window is judged after a same-cycle release has advanced the head;
  // a restore of the just-released slot lands outside the window and is dropped.
  assign rst_off   = ckpt_restore_id_in - head_rel;
  assign rst_ok    = rdy_in & ~flush_in & ckpt_restore_in & ({1'b0, rst_off} < count_rel);
  assign sav_ok    = rdy_in & ~flush_in & ~rst_ok & ckpt_save_in & ~full;
  assign byp       = rdy_in & ~flush_in & ~rst_ok;

  assign ckpt_id_out    = tail;
  assign ckpt_full_out  = full;
  assign ckpt_empty_out = (count == '0);

  always_comb begin
    tag_nx  = tag;
    busy_nx = busy;
    if (cmt_ok && tag[cmt_id_in] == cmt_tag_in) busy_nx[cmt_id_in] = 1'b0;
    if (ren_ok) begin
      tag_nx[ren_id_in]  = ren_tag_in;
      busy_nx[ren_id_in] = 1'b1;
    end
  end

  always_comb begin
    rst_busy = '0;
    for (int r = 0; r < NUM_REGS; r++)
      rst_busy[r] = s_busy[ckpt_restore_id_in][r] &
                    ~(cmt_ok && cmt_id_in == 5'(r) &&
                      s_tag[ckpt_restore_id_in][r] == cmt_tag_in);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < NUM_REGS; r++) val[r] <= '0;
      tag   <= '0;
      busy  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (cmt_ok) val[cmt_id_in] <= cmt_val_in;
      if (flush_in) begin
        tag   <= '0;
        busy  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (rst_ok) begin
        tag   <= s_tag[ckpt_restore_id_in];
        busy  <= rst_busy;
        head  <= head_rel;
        tail  <= ckpt_restore_id_in;
        count <= {1'b0, rst_off};
      end else begin
        tag   <= tag_nx;
        busy  <= busy_nx;
        head  <= head_rel;
        tail  <= tail + CKPT_W'(sav_ok);
        count <= count_rel + (CKPT_W+1)'(sav_ok);
      end
    end
  end

  // Commits scrub every slot so a later restore cannot revive a retired producer.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int s = 0; s < CKPT_DEPTH; s++)
        for (int r = 0; r < NUM_REGS; r++)
          if (cmt_ok && cmt_id_in == 5'(r) && s_tag[s][r] == cmt_tag_in)
            s_busy[s][r] <= 1'b0;
      if (sav_ok) begin
        s_tag[tail]  <= tag_nx;
        s_busy[tail] <= busy_nx;
      end
    end
  end

  always_comb begin
    rd_val_out  = '0;
    rd_tag_out  = '0;
    rd_busy_out = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_id_in[5*k +: 5] != 5'd0) begin
        rd_val_out[k*XLEN +: XLEN]   = val[rd_id_in[5*k +: 5]];
        rd_tag_out[k*TAG_W +: TAG_W] = tag[rd_id_in[5*k +: 5]];
        rd_busy_out[k]               = busy[rd_id_in[5*k +: 5]];
        if (byp && cmt_ok && cmt_id_in == rd_id_in[5*k +: 5]) begin
          rd_val_out[k*XLEN +: XLEN] = cmt_val_in;
          if (cmt_tag_in == tag[rd_id_in[5*k +: 5]]) rd_busy_out[k] = 1'b0;
        end
        if (byp && ren_ok && ren_id_in == rd_id_in[5*k +: 5]) begin
          rd_tag_out[k*TAG_W +: TAG_W] = ren_tag_in;
          rd_busy_out[k]               = 1'b1;
        end
      end
    end
  end

endmodule
